// File: rtl/frogger_pkg.sv
// Shared types and HID keycode constants for the frog game blocks.
package frogger_pkg;

    localparam logic [7:0] HID_NONE = 8'h00;
    localparam logic [7:0] HID_W    = 8'h1A;
    localparam logic [7:0] HID_A    = 8'h04;
    localparam logic [7:0] HID_S    = 8'h16;
    localparam logic [7:0] HID_D    = 8'h07;

    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, FIRE, COOL, HELD} hop_state_t;

endpackage

// File: rtl/key_dir_decode.sv
// Combinational HID keycode to direction decode; unknown codes map to DIR_NONE.
module key_dir_decode
    import frogger_pkg::*;
#(
    parameter logic [7:0] KEY_UP    = HID_W,
    parameter logic [7:0] KEY_LEFT  = HID_A,
    parameter logic [7:0] KEY_DOWN  = HID_S,
    parameter logic [7:0] KEY_RIGHT = HID_D
) (
    input  logic [7:0] i_keycode,
    output dir_t       o_dir
);

    always_comb begin
        o_dir = DIR_NONE;
        if      (i_keycode == KEY_UP)    o_dir = DIR_UP;
        else if (i_keycode == KEY_DOWN)  o_dir = DIR_DOWN;
        else if (i_keycode == KEY_LEFT)  o_dir = DIR_LEFT;
        else if (i_keycode == KEY_RIGHT) o_dir = DIR_RIGHT;
    end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Keycode to one-frame hop pulses with cooldown and hold-to-repeat, clocked per video frame.
module frog_hop_ctrl
    import frogger_pkg::*;
#(
    parameter logic [7:0] KEY_UP        = HID_W,
    parameter logic [7:0] KEY_LEFT      = HID_A,
    parameter logic [7:0] KEY_DOWN      = HID_S,
    parameter logic [7:0] KEY_RIGHT     = HID_D,
    parameter int         COOL_FRAMES   = 6,
    parameter int         REPEAT_FRAMES = 15
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       enable,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       busy,
    output logic [7:0] hop_count
);

    localparam logic [7:0] COOL_LOAD = 8'(COOL_FRAMES - 1);
    localparam logic [7:0] REP_LOAD  = 8'(REPEAT_FRAMES - 1);

    dir_t       w_dir;
    dir_t       r_dir;
    hop_state_t r_state;
    logic [7:0] r_cnt;
    logic       w_fire;

    key_dir_decode #(
        .KEY_UP   (KEY_UP),
        .KEY_LEFT (KEY_LEFT),
        .KEY_DOWN (KEY_DOWN),
        .KEY_RIGHT(KEY_RIGHT)
    ) u_dec (
        .i_keycode(keycode),
        .o_dir    (w_dir)
    );

    // Pulses are registered from the FIRE state, so they trail FIRE by one frame.
    assign w_fire = enable && (r_state == FIRE);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_dir     <= DIR_NONE;
            r_cnt     <= 8'd0;
            up        <= 1'b0;
            down      <= 1'b0;
            left      <= 1'b0;
            right     <= 1'b0;
            busy      <= 1'b0;
            hop_count <= 8'd0;
        end else begin
            up    <= w_fire && (r_dir == DIR_UP);
            down  <= w_fire && (r_dir == DIR_DOWN);
            left  <= w_fire && (r_dir == DIR_LEFT);
            right <= w_fire && (r_dir == DIR_RIGHT);
            busy  <= (r_state != IDLE);
            if (!enable) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_dir != DIR_NONE) begin
                            r_dir   <= w_dir;
                            r_state <= FIRE;
                            if (hop_count != 8'hFF) hop_count <= hop_count + 8'd1;
                        end
                    end
                    FIRE: begin
                        r_cnt   <= COOL_LOAD;
                        r_state <= COOL;
                    end
                    COOL: begin
                        if (r_cnt == 8'd0) begin
                            if (w_dir == r_dir) begin
                                r_cnt   <= REP_LOAD;
                                r_state <= HELD;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    HELD: begin
                        if (w_dir != r_dir) begin
                            r_state <= IDLE;
                        end else if (r_cnt == 8'd0) begin
                            r_state <= FIRE;
                            if (hop_count != 8'hFF) hop_count <= hop_count + 8'd1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed bench for frog_hop_ctrl: default-parameter instance plus a fast-repeat instance for saturation.
module tb_frog_hop_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] key;
    logic       en;
    logic       up, down, left, right, busy;
    logic [7:0] hops;

    logic [7:0] key_s;
    logic       en_s;
    logic       s_up, s_down, s_left, s_right, s_busy;
    logic [7:0] s_hops;

    int checks;
    int failures;

    frog_hop_ctrl dut (
        .frame_clk(clk), .Reset_n(rst_n), .keycode(key), .enable(en),
        .up(up), .down(down), .left(left), .right(right),
        .busy(busy), .hop_count(hops)
    );

    frog_hop_ctrl #(.COOL_FRAMES(1), .REPEAT_FRAMES(1)) dut_s (
        .frame_clk(clk), .Reset_n(rst_n), .keycode(key_s), .enable(en_s),
        .up(s_up), .down(s_down), .left(s_left), .right(s_right),
        .busy(s_busy), .hop_count(s_hops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key = 8'h00; en = 1'b0;
        key_s = 8'h00; en_s = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({up, down, left, right, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000", {up, down, left, right, busy});
        end
        checks++;
        if (hops !== 8'h00) begin
            failures++;
            $display("FAIL reset_hop_count got=%h want=00", hops);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_tap();
        do_reset();
        en = 1'b1; key = 8'h1A;
        tick();
        key = 8'h00;
        checks++;
        if (up !== 1'b0) begin failures++; $display("FAIL tap_up_edge0 got=%b want=0", up); end
        tick();
        checks++;
        if ({up, down, left, right} !== 4'b1000) begin
            failures++; $display("FAIL tap_pulse got=%b want=1000", {up, down, left, right});
        end
        tick();
        checks++;
        if (up !== 1'b0) begin failures++; $display("FAIL tap_up_edge2 got=%b want=0", up); end
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL tap_busy_edge7 got=%b want=1", busy); end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL tap_busy_edge8 got=%b want=0", busy); end
        checks++;
        if (hops !== 8'd1) begin failures++; $display("FAIL tap_hop_count got=%0d want=1", hops); end
    endtask

    task automatic test_hold();
        logic [63:0] mask;
        int other;
        mask = 64'd0; other = 0;
        do_reset();
        en = 1'b1; key = 8'h07;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (right) mask[c] = 1'b1;
            if (up || down || left) other++;
        end
        checks++;
        if (mask !== ((64'd1 << 1) | (64'd1 << 23) | (64'd1 << 45))) begin
            failures++; $display("FAIL hold_right_cycles got=%h want=%h", mask,
                                 (64'd1 << 1) | (64'd1 << 23) | (64'd1 << 45));
        end
        checks++;
        if (other != 0) begin failures++; $display("FAIL hold_other_dirs got=%0d want=0", other); end
        checks++;
        if (hops !== 8'd3) begin failures++; $display("FAIL hold_hop_count got=%0d want=3", hops); end
    endtask

    task automatic test_change_cool();
        logic [31:0] ml, md;
        int other;
        ml = 32'd0; md = 32'd0; other = 0;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            key = (c < 3) ? 8'h04 : 8'h16;
            tick();
            if (left) ml[c] = 1'b1;
            if (down) md[c] = 1'b1;
            if (up || right) other++;
        end
        checks++;
        if (ml !== 32'h0000_0002) begin failures++; $display("FAIL change_left got=%h want=00000002", ml); end
        checks++;
        if (md !== 32'h0000_0200) begin failures++; $display("FAIL change_down got=%h want=00000200", md); end
        checks++;
        if (other != 0 || hops !== 8'd2) begin
            failures++; $display("FAIL change_other_hops got=%0d/%0d want=0/2", other, hops);
        end
    endtask

    task automatic test_ignore_disable();
        int seen;
        do_reset();
        en = 1'b1; key = 8'h2C; seen = 0;
        repeat (10) begin tick(); if (up || down || left || right || busy) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL ignored_key got=%0d want=0", seen); end
        en = 1'b0; key = 8'h1A; seen = 0;
        repeat (10) begin tick(); if (up || down || left || right) seen++; end
        checks++;
        if (seen != 0 || hops !== 8'd0) begin
            failures++; $display("FAIL disabled_key got=%0d/%0d want=0/0", seen, hops);
        end
        // Enter HELD (edges 7..21), then drop enable at edge 11.
        en = 1'b1;
        repeat (11) tick();
        en = 1'b0; seen = 0;
        repeat (30) begin tick(); if (up || down || left || right) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL drop_enable_pulses got=%0d want=0", seen); end
        checks++;
        if (busy !== 1'b0 || hops !== 8'd1) begin
            failures++; $display("FAIL drop_enable_state got=%b/%0d want=0/1", busy, hops);
        end
        en = 1'b1;
        tick();
        tick();
        checks++;
        if (up !== 1'b1 || hops !== 8'd2) begin
            failures++; $display("FAIL reenable_fire got=%b/%0d want=1/2", up, hops);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; key = 8'h1A;
        tick();
        tick();
        checks++;
        if (up !== 1'b1) begin failures++; $display("FAIL areset_pre_up got=%b want=1", up); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({up, busy} !== 2'b00 || hops !== 8'd0) begin
            failures++; $display("FAIL areset_clear got=%b%b/%0d want=00/0", up, busy, hops);
        end
        key = 8'h00;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL areset_idle got=%b want=0", busy); end
        key = 8'h1A;
        tick();
        key = 8'h00;
        tick();
        checks++;
        if (up !== 1'b1 || hops !== 8'd1) begin
            failures++; $display("FAIL areset_refire got=%b/%0d want=1/1", up, hops);
        end
    endtask

    task automatic test_saturation();
        int pulses;
        do_reset();
        en_s = 1'b1; key_s = 8'h1A;
        repeat (600) tick();
        checks++;
        if (s_hops !== 8'd200) begin failures++; $display("FAIL sat_mid got=%0d want=200", s_hops); end
        repeat (300) tick();
        checks++;
        if (s_hops !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%h want=ff", s_hops); end
        pulses = 0;
        repeat (30) begin tick(); if (s_up) pulses++; end
        checks++;
        if (pulses != 10 || s_hops !== 8'hFF) begin
            failures++; $display("FAIL sat_continue got=%0d/%h want=10/ff", pulses, s_hops);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        key = 8'h00; en = 1'b0; key_s = 8'h00; en_s = 1'b0;
        test_reset();
        test_single_tap();
        test_hold();
        test_change_cool();
        test_ignore_disable();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
